// File: rtl/clk_mon_pkg.sv
// Shared types for the divided-clock period/duty monitor.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEAS,
    HOLD
  } state_t;

  // Half-sample offset of each transition position from the previous posedge sample.
  localparam logic [1:0] POS1 = 2'd1;  // prev s_p -> s_n
  localparam logic [1:0] POS2 = 2'd2;  // s_n -> current s_p

endpackage

// File: rtl/clk_edge_sampler.sv
// Samples clk_in on both edges of clk and reports the two half-sample transitions
// that each posedge of clk evaluates.
module clk_edge_sampler (
  input  logic clk,
  input  logic rstn,
  input  logic clk_in,
  output logic rise1,
  output logic rise2,
  output logic fall1,
  output logic fall2
);

  logic r_s_n;
  logic r_s_p;

  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s_n <= 1'b0;
    end else begin
      r_s_n <= clk_in;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s_p <= 1'b0;
    end else begin
      r_s_p <= clk_in;
    end
  end

  // clk_in itself is the current posedge sample, so results land on the evaluating edge.
  assign rise1 = ~r_s_p & r_s_n;
  assign fall1 = r_s_p & ~r_s_n;
  assign rise2 = ~r_s_n & clk_in;
  assign fall2 = r_s_n & ~clk_in;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period and high time of a divided clock in half-cycles of clk and
// reports them, with a duty-cycle verdict, over a valid/ready handshake.
module clk_div_monitor
  import clk_mon_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int TOL   = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clk_in,
  input  logic             en,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] period_hc,
  output logic [CNT_W-1:0] high_hc,
  output logic             duty_err,
  output logic             ovf,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W+1:0] DUTY_TOL = (CNT_W+2)'(2 * TOL);

  state_t                  r_state, w_state_next;
  logic [CNT_W-1:0]        r_cnt, w_cnt_next;
  logic                    r_fall_seen, w_fall_seen_next;
  logic [CNT_W-1:0]        r_high_cap, w_high_cap_next;
  logic                    r_valid, w_valid_next;
  logic [CNT_W-1:0]        r_period, r_high;
  logic                    r_duty_err, r_ovf;

  logic                    w_rise1, w_rise2, w_fall1, w_fall2;
  logic [CNT_W-1:0]        w_cnt_p1, w_cnt_p2;
  logic                    w_fs1, w_fs2;
  logic [CNT_W-1:0]        w_hc1, w_hc2;
  logic                    w_close;
  logic [CNT_W-1:0]        w_close_period, w_close_high;
  logic                    w_close_ovf, w_close_err;
  logic signed [CNT_W+1:0] w_diff;
  logic [CNT_W+1:0]        w_abs;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
    return sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
  endfunction

  clk_edge_sampler u_sampler (
    .clk    (clk),
    .rstn   (rstn),
    .clk_in (clk_in),
    .rise1  (w_rise1),
    .rise2  (w_rise2),
    .fall1  (w_fall1),
    .fall2  (w_fall2)
  );

  // r_cnt is the count at the last posedge sample; fall capture is ordered pos 1 then pos 2.
  assign w_cnt_p1 = sat_add(r_cnt, POS1);
  assign w_cnt_p2 = sat_add(r_cnt, POS2);
  assign w_fs1    = r_fall_seen | w_fall1;
  assign w_hc1    = r_fall_seen ? r_high_cap : w_cnt_p1;
  assign w_fs2    = w_fs1 | w_fall2;
  assign w_hc2    = w_fs1 ? w_hc1 : w_cnt_p2;

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_fall_seen_next = r_fall_seen;
    w_high_cap_next  = r_high_cap;
    w_valid_next     = r_valid;
    w_close          = 1'b0;
    w_close_period   = CNT_MAX;
    w_close_high     = CNT_MAX;
    unique case (r_state)
      IDLE: begin
        if (en) w_state_next = ARM;
      end
      ARM: begin
        if (!en) begin
          w_state_next = IDLE;
        end else if (w_rise1) begin
          w_state_next     = MEAS;
          w_cnt_next       = CNT_W'(POS2 - POS1);
          w_fall_seen_next = w_fall2;
          w_high_cap_next  = CNT_W'(POS2 - POS1);
        end else if (w_rise2) begin
          w_state_next     = MEAS;
          w_cnt_next       = '0;
          w_fall_seen_next = 1'b0;
          w_high_cap_next  = '0;
        end
      end
      MEAS: begin
        if (!en) begin
          w_state_next = IDLE;
        end else if (w_rise1) begin
          w_close        = 1'b1;
          w_close_period = w_cnt_p1;
          w_close_high   = r_fall_seen ? r_high_cap : CNT_MAX;
        end else if (w_rise2) begin
          w_close        = 1'b1;
          w_close_period = w_cnt_p2;
          w_close_high   = w_fs1 ? w_hc1 : CNT_MAX;
        end else if (w_cnt_p2 == CNT_MAX) begin
          w_close        = 1'b1;
          w_close_period = CNT_MAX;
          w_close_high   = w_fs2 ? w_hc2 : CNT_MAX;
        end else begin
          w_cnt_next       = w_cnt_p2;
          w_fall_seen_next = w_fs2;
          w_high_cap_next  = w_hc2;
        end
        if (w_close) begin
          w_state_next = HOLD;
          w_valid_next = 1'b1;
        end
      end
      HOLD: begin
        if (meas_ready) begin
          w_valid_next = 1'b0;
          w_state_next = en ? ARM : IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_close_ovf = (w_close_period == CNT_MAX);
  assign w_diff      = $signed({1'b0, w_close_high, 1'b0}) - $signed({2'b00, w_close_period});
  assign w_abs       = w_diff[CNT_W+1] ? $unsigned(-w_diff) : $unsigned(w_diff);
  assign w_close_err = w_close_ovf | (w_abs > DUTY_TOL);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_fall_seen <= 1'b0;
      r_high_cap  <= '0;
      r_valid     <= 1'b0;
      r_period    <= '0;
      r_high      <= '0;
      r_duty_err  <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_fall_seen <= w_fall_seen_next;
      r_high_cap  <= w_high_cap_next;
      r_valid     <= w_valid_next;
      if (w_close) begin
        r_period   <= w_close_period;
        r_high     <= w_close_high;
        r_duty_err <= w_close_err;
        r_ovf      <= w_close_ovf;
      end
    end
  end

  assign meas_valid = r_valid;
  assign period_hc  = r_period;
  assign high_hc    = r_high;
  assign duty_err   = r_duty_err;
  assign ovf        = r_ovf;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor; a half-cycle pattern generator stands in for the divider.
module tb_clk_div_monitor;

  localparam int CNT_W = 6;
  localparam int TOL   = 1;

  logic             clk        = 1'b0;
  logic             rstn       = 1'b0;
  logic             clk_in     = 1'b0;
  logic             en         = 1'b0;
  logic             meas_ready = 1'b1;
  logic             meas_valid;
  logic [CNT_W-1:0] period_hc;
  logic [CNT_W-1:0] high_hc;
  logic             duty_err;
  logic             ovf;
  logic             busy;

  int n_checks  = 0;
  int n_errors  = 0;
  int n_xfers   = 0;
  int gen_p     = 8;
  int gen_h     = 0;
  int gen_epoch = 0;
  int gen_ph    = 0;
  int gen_seen  = 0;
  int xfer_base = 0;

  // Pattern table: period and high time in half-cycles, expected duty_err at TOL=1.
  int pat_p   [8] = '{8, 6, 16, 4, 6, 2, 8, 8};
  int pat_h   [8] = '{4, 3,  6, 1, 1, 1, 3, 2};
  int pat_err [8] = '{0, 0,  1, 0, 1, 0, 0, 1};

  clk_div_monitor #(
    .CNT_W (CNT_W),
    .TOL   (TOL)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .clk_in     (clk_in),
    .en         (en),
    .meas_valid (meas_valid),
    .meas_ready (meas_ready),
    .period_hc  (period_hc),
    .high_hc    (high_hc),
    .duty_err   (duty_err),
    .ovf        (ovf),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // clk_in changes just after each clk edge; a new epoch restarts the pattern high.
  always @(clk) begin
    #1;
    if (gen_seen != gen_epoch) begin
      gen_seen = gen_epoch;
      gen_ph   = 0;
    end
    clk_in = (gen_ph < gen_h);
    gen_ph = (gen_ph + 1) % gen_p;
  end

  // A transfer happens at the posedge following a negedge with valid and ready both high.
  always @(negedge clk) begin
    if (rstn && meas_valid && meas_ready) begin
      n_xfers++;
      $display("xfer %0d: period_hc=%0d high_hc=%0d duty_err=%0b ovf=%0b",
               n_xfers, period_hc, high_hc, duty_err, ovf);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_pattern(input int p, input int h);
    @(negedge clk);
    #2;
    gen_p = p;
    gen_h = h;
    gen_epoch++;
  endtask

  task automatic go_idle();
    en         = 1'b0;
    meas_ready = 1'b1;
    repeat (3) tick();
    check_eq("idle_busy", busy, 0);
  endtask

  task automatic wait_rise();
    logic prev;
    prev = clk_in;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (clk_in && !prev) break;
      prev = clk_in;
    end
  endtask

  task automatic expect_result(input string tag, input int per, input int hi,
                               input int err, input int ov, input int gap);
    int cyc;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!meas_valid && cyc < 300);
    check_eq({tag, "_valid"},  meas_valid, 1);
    check_eq({tag, "_period"}, period_hc, per);
    check_eq({tag, "_high"},   high_hc, hi);
    check_eq({tag, "_duty"},   duty_err, err);
    check_eq({tag, "_ovf"},    ovf, ov);
    if (gap > 0) check_eq({tag, "_gap"}, cyc, gap);
  endtask

  initial begin
    rstn       = 1'b0;
    en         = 1'b0;
    meas_ready = 1'b1;
    repeat (3) tick();
    check_eq("rst_valid",  meas_valid, 0);
    check_eq("rst_period", period_hc, 0);
    check_eq("rst_high",   high_hc, 0);
    check_eq("rst_duty",   duty_err, 0);
    check_eq("rst_ovf",    ovf, 0);
    check_eq("rst_busy",   busy, 0);
    rstn = 1'b1;

    // Two consecutive results per pattern; with ready high they are two clk_in periods apart.
    for (int i = 0; i < 8; i++) begin
      go_idle();
      set_pattern(pat_p[i], pat_h[i]);
      repeat (2) tick();
      en = 1'b1;
      check_eq("busy_before", busy, 0);
      tick();
      check_eq("busy_after", busy, 1);
      expect_result($sformatf("p%0d_h%0d_a", pat_p[i], pat_h[i]),
                    pat_p[i], pat_h[i], pat_err[i], 0, 0);
      expect_result($sformatf("p%0d_h%0d_b", pat_p[i], pat_h[i]),
                    pat_p[i], pat_h[i], pat_err[i], 0, (pat_p[i] >= 4) ? pat_p[i] : 0);
    end

    // Consumer stalls for 20 cycles in HOLD.
    go_idle();
    set_pattern(8, 4);
    meas_ready = 1'b0;
    repeat (2) tick();
    en = 1'b1;
    expect_result("stall", 8, 4, 0, 0, 0);
    xfer_base = n_xfers;
    repeat (20) begin
      tick();
      check_eq("stall_valid",  meas_valid, 1);
      check_eq("stall_period", period_hc, 8);
      check_eq("stall_high",   high_hc, 4);
      check_eq("stall_duty",   duty_err, 0);
    end
    meas_ready = 1'b1;
    tick();
    check_eq("stall_released", meas_valid, 0);
    check_eq("stall_xfers", n_xfers - xfer_base, 1);

    // en dropped one cycle into MEAS: back to IDLE, no result.
    go_idle();
    meas_ready = 1'b0;
    en = 1'b1;
    repeat (2) tick();
    wait_rise();
    repeat (2) tick();
    en = 1'b0;
    check_eq("endrop_busy_meas", busy, 1);
    tick();
    check_eq("endrop_busy", busy, 0);
    repeat (20) tick();
    check_eq("endrop_valid", meas_valid, 0);

    // Asynchronous reset while measuring clears held results immediately.
    meas_ready = 1'b1;
    en = 1'b1;
    expect_result("prerst", 8, 4, 0, 0, 0);
    wait_rise();
    repeat (2) tick();
    rstn = 1'b0;
    #1;
    check_eq("midrst_valid",  meas_valid, 0);
    check_eq("midrst_period", period_hc, 0);
    check_eq("midrst_high",   high_hc, 0);
    check_eq("midrst_duty",   duty_err, 0);
    check_eq("midrst_ovf",    ovf, 0);
    check_eq("midrst_busy",   busy, 0);
    #1;
    rstn = 1'b1;
    expect_result("postrst", 8, 4, 0, 0, 0);

    // Stuck low waits in ARM forever; then stuck high saturates the 6-bit counter.
    go_idle();
    set_pattern(8, 0);
    en = 1'b1;
    repeat (100) tick();
    check_eq("stuck_low_busy",  busy, 1);
    check_eq("stuck_low_valid", meas_valid, 0);
    set_pattern(8, 99);
    expect_result("stuck_high", 63, 63, 1, 1, 0);
    en = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
